// File: rtl/instruction_decode_unit_pkg.sv
// Shared MIPS decode definitions: opcode/funct constants, ALU op encodings,
// the NOP encoding and the ID/EX pipeline record used by the decode stage.
package instruction_decode_unit_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_COUNT  = 32;

    localparam logic [31:0] NOP_ENCODING = 32'h0000_0000;

    localparam logic [5:0] OPCODE_RTYPE = 6'h00;
    localparam logic [5:0] OPCODE_J     = 6'h02;
    localparam logic [5:0] OPCODE_BEQ   = 6'h04;
    localparam logic [5:0] OPCODE_ADDI  = 6'h08;
    localparam logic [5:0] OPCODE_LW    = 6'h23;
    localparam logic [5:0] OPCODE_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLT = 4'd4
    } alu_op_e;

    typedef struct packed {
        logic                  valid;
        logic [DATA_W-1:0]     pc_plus4;
        logic [DATA_W-1:0]     read_data_1;
        logic [DATA_W-1:0]     read_data_2;
        logic [DATA_W-1:0]     immediate;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     jump_target;
        alu_op_e               alu_op;
        logic                  alu_src;
        logic                  reg_dst;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic                  reg_write;
        logic                  branch;
        logic                  jump;
        logic                  illegal;
    } id_ex_t;

    function automatic logic [DATA_W-1:0] sign_extend_imm(input logic [15:0] imm);
        return {{(DATA_W-16){imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/instruction_decode_unit_register_file.sv
// 32x32 register file: two combinational reads, one clocked write, $0 hardwired
// to zero. Optional write-before-read bypass under ID_REGFILE_BYPASS_EN.
module register_file
    import instruction_decode_unit_pkg::*;
(
    input  logic                  system_clock,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] read_register_1,
    input  logic [REG_ADDR_W-1:0] read_register_2,
    output logic [DATA_W-1:0]     read_data_1,
    output logic [DATA_W-1:0]     read_data_2,
    input  logic                  write_enable,
    input  logic [REG_ADDR_W-1:0] write_register,
    input  logic [DATA_W-1:0]     write_data
);

    logic [DATA_W-1:0] registers [REG_COUNT];
    logic              write_live;

    assign write_live = write_enable && (write_register != '0);

    always_ff @(posedge system_clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                registers[i] <= '0;
            end
        end else if (write_live) begin
            registers[write_register] <= write_data;
        end
    end

    always_comb begin
        read_data_1 = (read_register_1 == '0) ? '0 : registers[read_register_1];
`ifdef ID_REGFILE_BYPASS_EN
        if (write_live && (write_register == read_register_1)) begin
            read_data_1 = write_data;
        end
`endif
    end

    always_comb begin
        read_data_2 = (read_register_2 == '0) ? '0 : registers[read_register_2];
`ifdef ID_REGFILE_BYPASS_EN
        if (write_live && (write_register == read_register_2)) begin
            read_data_2 = write_data;
        end
`endif
    end

endmodule

// File: rtl/instruction_decode_unit.sv
// MIPS decode stage: IF/ID register, register-file read, control decode, ID/EX
// register. Build option ID_REGFILE_BYPASS_EN enables write-before-read bypass.
module instruction_decode_unit
    import instruction_decode_unit_pkg::*;
#(
    parameter logic [31:0] NOP_INSTRUCTION = NOP_ENCODING
) (
    input  logic        system_clock,
    input  logic        reset,
    input  logic [31:0] if_instruction,
    input  logic [31:0] if_pc_plus4,
    input  logic        if_valid,
    input  logic        stall,
    input  logic        flush,
    input  logic        wb_write_enable,
    input  logic [4:0]  wb_write_register,
    input  logic [31:0] wb_write_data,
    output logic        id_valid,
    output logic [31:0] id_pc_plus4,
    output logic [31:0] id_read_data_1,
    output logic [31:0] id_read_data_2,
    output logic [31:0] id_immediate,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd,
    output logic [31:0] id_jump_target,
    output logic [3:0]  id_alu_op,
    output logic        id_alu_src,
    output logic        id_reg_dst,
    output logic        id_mem_read,
    output logic        id_mem_write,
    output logic        id_mem_to_reg,
    output logic        id_reg_write,
    output logic        id_branch,
    output logic        id_jump,
    output logic        id_illegal
);

    logic [31:0]       instr_p0;
    logic [31:0]       pc_plus4_p0;
    logic              vld_p0;
    logic [DATA_W-1:0] rf_read_data_1;
    logic [DATA_W-1:0] rf_read_data_2;
    id_ex_t            decoded_p0;
    id_ex_t            id_ex_p1;
    logic [5:0]        opcode;
    logic [5:0]        funct;

    // Stage p0: IF/ID register
    always_ff @(posedge system_clock or negedge reset) begin
        if (!reset) begin
            instr_p0    <= NOP_INSTRUCTION;
            pc_plus4_p0 <= '0;
            vld_p0      <= 1'b0;
        end else if (flush) begin
            instr_p0    <= NOP_INSTRUCTION;
            pc_plus4_p0 <= '0;
            vld_p0      <= 1'b0;
        end else if (!stall) begin
            instr_p0    <= if_instruction;
            pc_plus4_p0 <= if_pc_plus4;
            vld_p0      <= if_valid;
        end
    end

    register_file u_register_file (
        .system_clock    (system_clock),
        .reset           (reset),
        .read_register_1 (instr_p0[25:21]),
        .read_register_2 (instr_p0[20:16]),
        .read_data_1     (rf_read_data_1),
        .read_data_2     (rf_read_data_2),
        .write_enable    (wb_write_enable),
        .write_register  (wb_write_register),
        .write_data      (wb_write_data)
    );

    assign opcode = instr_p0[31:26];
    assign funct  = instr_p0[5:0];

    always_comb begin
        decoded_p0             = '0;
        decoded_p0.valid       = 1'b1;
        decoded_p0.pc_plus4    = pc_plus4_p0;
        decoded_p0.read_data_1 = rf_read_data_1;
        decoded_p0.read_data_2 = rf_read_data_2;
        decoded_p0.immediate   = sign_extend_imm(instr_p0[15:0]);
        decoded_p0.rs          = instr_p0[25:21];
        decoded_p0.rt          = instr_p0[20:16];
        decoded_p0.rd          = instr_p0[15:11];
        decoded_p0.jump_target = {pc_plus4_p0[31:28], instr_p0[25:0], 2'b00};
        decoded_p0.alu_op      = ALU_ADD;

        unique case (opcode)
            OPCODE_RTYPE: begin
                decoded_p0.reg_dst   = 1'b1;
                decoded_p0.reg_write = 1'b1;
                unique case (funct)
                    FUNCT_ADD: decoded_p0.alu_op = ALU_ADD;
                    FUNCT_SUB: decoded_p0.alu_op = ALU_SUB;
                    FUNCT_AND: decoded_p0.alu_op = ALU_AND;
                    FUNCT_OR:  decoded_p0.alu_op = ALU_OR;
                    FUNCT_SLT: decoded_p0.alu_op = ALU_SLT;
                    default: begin
                        // Unknown funct: keep the fields, drop every control.
                        decoded_p0.reg_dst   = 1'b0;
                        decoded_p0.reg_write = 1'b0;
                        decoded_p0.illegal   = 1'b1;
                    end
                endcase
            end
            OPCODE_LW: begin
                decoded_p0.alu_src    = 1'b1;
                decoded_p0.mem_read   = 1'b1;
                decoded_p0.mem_to_reg = 1'b1;
                decoded_p0.reg_write  = 1'b1;
            end
            OPCODE_SW: begin
                decoded_p0.alu_src   = 1'b1;
                decoded_p0.mem_write = 1'b1;
            end
            OPCODE_BEQ: begin
                decoded_p0.alu_op = ALU_SUB;
                decoded_p0.branch = 1'b1;
            end
            OPCODE_ADDI: begin
                decoded_p0.alu_src   = 1'b1;
                decoded_p0.reg_write = 1'b1;
            end
            OPCODE_J: begin
                decoded_p0.jump = 1'b1;
            end
            default: begin
                decoded_p0.illegal = 1'b1;
            end
        endcase
    end

    // Stage p1: ID/EX register; stalls, flushes and empty slots become bubbles
    always_ff @(posedge system_clock or negedge reset) begin
        if (!reset) begin
            id_ex_p1 <= '0;
        end else if (stall || flush || !vld_p0) begin
            id_ex_p1 <= '0;
        end else begin
            id_ex_p1 <= decoded_p0;
        end
    end

    assign id_valid       = id_ex_p1.valid;
    assign id_pc_plus4    = id_ex_p1.pc_plus4;
    assign id_read_data_1 = id_ex_p1.read_data_1;
    assign id_read_data_2 = id_ex_p1.read_data_2;
    assign id_immediate   = id_ex_p1.immediate;
    assign id_rs          = id_ex_p1.rs;
    assign id_rt          = id_ex_p1.rt;
    assign id_rd          = id_ex_p1.rd;
    assign id_jump_target = id_ex_p1.jump_target;
    assign id_alu_op      = id_ex_p1.alu_op;
    assign id_alu_src     = id_ex_p1.alu_src;
    assign id_reg_dst     = id_ex_p1.reg_dst;
    assign id_mem_read    = id_ex_p1.mem_read;
    assign id_mem_write   = id_ex_p1.mem_write;
    assign id_mem_to_reg  = id_ex_p1.mem_to_reg;
    assign id_reg_write   = id_ex_p1.reg_write;
    assign id_branch      = id_ex_p1.branch;
    assign id_jump        = id_ex_p1.jump;
    assign id_illegal     = id_ex_p1.illegal;

endmodule

// File: tb/tb_instruction_decode_unit.sv
// Directed bench for instruction_decode_unit: transaction-level model checked
// every cycle, plus hand-computed literal expectations.
`timescale 1ns/1ps
module tb_instruction_decode_unit;

    logic        system_clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] if_instruction = '0;
    logic [31:0] if_pc_plus4 = '0;
    logic        if_valid = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        wb_write_enable = 1'b0;
    logic [4:0]  wb_write_register = '0;
    logic [31:0] wb_write_data = '0;
    logic        id_valid;
    logic [31:0] id_pc_plus4, id_read_data_1, id_read_data_2, id_immediate, id_jump_target;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [3:0]  id_alu_op;
    logic        id_alu_src, id_reg_dst, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        id_reg_write, id_branch, id_jump, id_illegal;

    instruction_decode_unit dut (
        .system_clock(system_clock), .reset(reset),
        .if_instruction(if_instruction), .if_pc_plus4(if_pc_plus4), .if_valid(if_valid),
        .stall(stall), .flush(flush),
        .wb_write_enable(wb_write_enable), .wb_write_register(wb_write_register),
        .wb_write_data(wb_write_data),
        .id_valid(id_valid), .id_pc_plus4(id_pc_plus4),
        .id_read_data_1(id_read_data_1), .id_read_data_2(id_read_data_2),
        .id_immediate(id_immediate), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_jump_target(id_jump_target), .id_alu_op(id_alu_op),
        .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .id_reg_write(id_reg_write), .id_branch(id_branch), .id_jump(id_jump),
        .id_illegal(id_illegal)
    );

    always #5 system_clock = ~system_clock;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rd1, rd2, imm;
        logic [4:0]  rs, rt, rd;
        logic [31:0] jt;
        logic [3:0]  op;
        logic [8:0]  ctl; // reg_dst alu_src mem_to_reg reg_write mem_read mem_write branch jump illegal
    } view_t;

    int    total = 0;
    int    bad = 0;
    bit    chk_en = 0;
    view_t exp_m;
    logic [31:0] m_regs [32];
    logic [31:0] m_instr, m_pc;
    logic        m_vld;

    function automatic view_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                           input logic [31:0] a, input logic [31:0] b);
        view_t e;
        e = '0;
        e.valid = 1'b1;
        e.pc = pc;
        e.rd1 = a;
        e.rd2 = b;
        e.imm = {{16{ins[15]}}, ins[15:0]};
        e.rs = ins[25:21];
        e.rt = ins[20:16];
        e.rd = ins[15:11];
        e.jt = {pc[31:28], ins[25:0], 2'b00};
        e.op = 4'd0;
        e.ctl = 9'b000000001;
        case (ins[31:26])
            6'h00: begin
                e.ctl = 9'b100100000;
                case (ins[5:0])
                    6'h20: e.op = 4'd0;
                    6'h22: e.op = 4'd1;
                    6'h24: e.op = 4'd2;
                    6'h25: e.op = 4'd3;
                    6'h2A: e.op = 4'd4;
                    default: e.ctl = 9'b000000001;
                endcase
            end
            6'h23: e.ctl = 9'b011110000;
            6'h2B: e.ctl = 9'b010001000;
            6'h04: begin e.ctl = 9'b000000100; e.op = 4'd1; end
            6'h08: e.ctl = 9'b010100000;
            6'h02: e.ctl = 9'b000000010;
            default: e.ctl = 9'b000000001;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] r);
        if (r == 5'd0) return 32'h0;
`ifdef ID_REGFILE_BYPASS_EN
        if (wb_write_enable && wb_write_register == r) return wb_write_data;
`endif
        return m_regs[r];
    endfunction

    always @(posedge system_clock or negedge reset) begin
        view_t nxt;
        if (!reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_instr = '0;
            m_pc = '0;
            m_vld = 1'b0;
            exp_m = '0;
        end else begin
            nxt = '0;
            if (!stall && !flush && m_vld)
                nxt = model_decode(m_instr, m_pc, model_read(m_instr[25:21]), model_read(m_instr[20:16]));
            if (wb_write_enable && wb_write_register != 5'd0) m_regs[wb_write_register] = wb_write_data;
            if (flush) begin
                m_instr = '0;
                m_vld = 1'b0;
            end else if (!stall) begin
                m_instr = if_instruction;
                m_pc = if_pc_plus4;
                m_vld = if_valid;
            end
            exp_m = nxt;
        end
    end

    function automatic view_t dut_view();
        view_t v;
        v.valid = id_valid; v.pc = id_pc_plus4; v.rd1 = id_read_data_1; v.rd2 = id_read_data_2;
        v.imm = id_immediate; v.rs = id_rs; v.rt = id_rt; v.rd = id_rd; v.jt = id_jump_target;
        v.op = id_alu_op;
        v.ctl = {id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read,
                 id_mem_write, id_branch, id_jump, id_illegal};
        return v;
    endfunction

    always @(negedge system_clock) begin
        view_t act;
        if (chk_en) begin
            act = dut_view();
            total++;
            if (act !== exp_m) begin
                bad++;
                $display("FAIL cycle_model at %0t actual=%h required=%h", $time, act, exp_m);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge system_clock);
        #1;
    endtask

    task automatic present(input logic [31:0] ins, input logic [31:0] pc);
        if_instruction = ins;
        if_pc_plus4 = pc;
        if_valid = 1'b1;
    endtask

    task automatic writeback(input logic we, input logic [4:0] r, input logic [31:0] d);
        wb_write_enable = we;
        wb_write_register = r;
        wb_write_data = d;
    endtask

    logic [31:0] burst [8];
    logic [31:0] bypass_req;

    initial begin
        burst[0] = 32'h00224024; // and $8,$1,$2
        burst[1] = 32'h0022502A; // slt $10,$1,$2
        burst[2] = 32'hAC220008; // sw $2,8($1)
        burst[3] = 32'h08000010; // j 0x10
        burst[4] = 32'h00225827; // nor: unsupported funct
        burst[5] = 32'h202B7FFF; // addi $11,$1,0x7FFF
        burst[6] = 32'h8C4CFFFC; // lw $12,-4($2)
        burst[7] = 32'h00221820; // add $3,$1,$2

        tick();
        chk_en = 1;
        tick();
        check("reset_valid", {31'h0, id_valid}, 32'h0);
        check("reset_rd1", id_read_data_1, 32'h0);
        check("reset_alu_op", {28'h0, id_alu_op}, 32'h0);
        check("reset_pc", id_pc_plus4, 32'h0);
        reset = 1'b1;

        writeback(1'b1, 5'd1, 32'd5); tick();
        writeback(1'b1, 5'd2, 32'd7); tick();
        writeback(1'b0, 5'd0, 32'h0);

        present(32'h00221820, 32'h0000_0100); tick();
        present(32'h2004FFFF, 32'h0000_0104); tick();
        check("add_rd1", id_read_data_1, 32'd5);
        check("add_rd2", id_read_data_2, 32'd7);
        check("add_rd", {27'h0, id_rd}, 32'd3);
        check("add_reg_write", {31'h0, id_reg_write}, 32'd1);
        check("add_alu_op", {28'h0, id_alu_op}, 32'd0);
        check("add_valid", {31'h0, id_valid}, 32'd1);
        if_valid = 1'b0; tick();
        check("addi_imm", id_immediate, 32'hFFFF_FFFF);
        check("addi_alu_src", {31'h0, id_alu_src}, 32'd1);
        check("addi_reg_dst", {31'h0, id_reg_dst}, 32'd0);

        present(32'h8D220000, 32'h0000_0108); tick();
        if_valid = 1'b0;
        writeback(1'b1, 5'd9, 32'hDEAD_BEEF); tick();
        writeback(1'b0, 5'd0, 32'h0);
`ifdef ID_REGFILE_BYPASS_EN
        bypass_req = 32'hDEAD_BEEF;
`else
        bypass_req = 32'h0;
`endif
        check("lw_bypass_rd1", id_read_data_1, bypass_req);
        check("lw_mem_read", {31'h0, id_mem_read}, 32'd1);

        present(32'h00642822, 32'h0000_010C); tick();
        present(32'h00223825, 32'h0000_0110);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_bubble", {31'h0, id_valid}, 32'd0);
        end
        stall = 1'b0;
        if_valid = 1'b0;
        tick();
        check("stall_release_valid", {31'h0, id_valid}, 32'd1);
        check("stall_release_op", {28'h0, id_alu_op}, 32'd1);
        check("stall_release_rd", {27'h0, id_rd}, 32'd5);
        tick();
        check("stall_once", {31'h0, id_valid}, 32'd0);

        present(32'h10220004, 32'h0000_0114); tick();
        if_valid = 1'b0;
        stall = 1'b1;
        flush = 1'b1;
        tick();
        check("flush_bubble", {31'h0, id_valid}, 32'd0);
        stall = 1'b0;
        flush = 1'b0;
        tick();
        check("flush_no_beq_valid", {31'h0, id_valid}, 32'd0);
        check("flush_no_beq_branch", {31'h0, id_branch}, 32'd0);

        present(32'hFC000000, 32'h0000_0118); tick();
        if_valid = 1'b0; tick();
        check("illegal_flag", {31'h0, id_illegal}, 32'd1);
        check("illegal_valid", {31'h0, id_valid}, 32'd1);
        check("illegal_reg_write", {31'h0, id_reg_write}, 32'd0);

        present(32'h00003020, 32'h0000_011C); tick();
        if_valid = 1'b0;
        writeback(1'b1, 5'd0, 32'h0000_1234); tick();
        writeback(1'b0, 5'd0, 32'h0);
        check("zero_reg_rd1", id_read_data_1, 32'h0);
        check("zero_reg_rd2", id_read_data_2, 32'h0);

        present(32'h08000010, 32'hA000_0004); tick();
        if_valid = 1'b0; tick();
        check("j_target", id_jump_target, 32'hA000_0040);
        check("j_jump", {31'h0, id_jump}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            present(burst[i], 32'hA000_0200 + 32'(i * 4));
            writeback(1'b1, 5'(i + 1), 32'h1000_0000 + 32'(i));
            stall = (i == 3);
            tick();
        end
        stall = 1'b0;
        if_valid = 1'b0;
        writeback(1'b0, 5'd0, 32'h0);
        tick();
        tick();

        present(32'h00221820, 32'h0000_0300); tick();
        present(32'h2004FFFF, 32'h0000_0304); tick();
        if_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("midreset_valid", {31'h0, id_valid}, 32'd0);
        check("midreset_rd1", id_read_data_1, 32'h0);
        check("midreset_pc", id_pc_plus4, 32'h0);
        tick();
        reset = 1'b1;
        present(32'h00221820, 32'h0000_0308); tick();
        if_valid = 1'b0; tick();
        check("post_reset_reg_cleared", id_read_data_1, 32'h0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
